vertex_mem_arbiter: RTL and testbench

Shares the single-port vertex RAM (DEPTH x DW) between two requesters: the vertex loader write stream and the vertex fetch read port used by the transform/raster stage.
The loader has no backpressure, so its writes land in a small write FIFO. The arbiter drains that FIFO into RAM and interleaves reads under a bounded write-burst rule.
Read-after-write ordering is guaranteed by a per-address hazard check against pending FIFO entries.
The block also reports an idle status, which the command dispatcher uses to sequence draw commands after loads.

---
 rtl/vertex_mem_pkg.sv | 28 ++
 rtl/vertex_wfifo.sv | 78 +++++++
 rtl/vertex_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_vertex_mem_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vertex_mem_pkg.sv
// Shared types for the vertex RAM arbiter.
// Grant states and vertex word field layout.
package vertex_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } gnt_state_t;

  localparam int VTX_X_LO     = 0;
  localparam int VTX_X_HI     = 15;
  localparam int VTX_Y_LO     = 16;
  localparam int VTX_Y_HI     = 31;
  localparam int VTX_Z_LO     = 32;
  localparam int VTX_Z_HI     = 47;
  localparam int VTX_COLOR_LO = 48;
  localparam int VTX_COLOR_HI = 55;
  localparam int VTX_UV_LO    = 60;
  localparam int VTX_UV_HI    = 63;

  function automatic logic [7:0] vtx_color(
    input logic [63:0] v
  );
    return v[VTX_COLOR_HI:VTX_COLOR_LO];
  endfunction

endpackage

// File: rtl/vertex_wfifo.sv
// Register write FIFO for the vertex loader stream.
// Exposes occupancy, head entry and a per-entry address match vector.
module vertex_wfifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 64,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [AW-1:0]    i_addr,
  input  logic [DW-1:0]    i_data,
  input  logic             i_pop,
  input  logic [AW-1:0]    i_q_addr,
  output logic [PW:0]      o_count,
  output logic             o_empty,
  output logic             o_drop,
  output logic [AW-1:0]    o_head_addr,
  output logic [DW-1:0]    o_head_data,
  output logic [DEPTH-1:0] o_match
);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_cnt;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_count     = r_cnt;
  assign o_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == (PW+1)'(DEPTH));
  assign w_pop       = i_pop && !o_empty;
  // a full FIFO still accepts a word when the head leaves this cycle
  assign w_push      = i_push && (!w_full || w_pop);
  assign o_drop      = i_push && !w_push;
  assign o_head_addr = r_addr[r_rp];
  assign o_head_data = r_data[r_rp];

  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = r_vld[i] && (r_addr[i] == i_q_addr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + PW'(1);
      end
      if (w_push) begin
        r_vld[r_wp] <= 1'b1;
        r_wp        <= r_wp + PW'(1);
      end
      r_cnt <= r_cnt + (PW+1)'(w_push)
                     - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wp] <= i_addr;
      r_data[r_wp] <= i_data;
    end
  end

endmodule

// File: rtl/vertex_mem_arbiter.sv
// Vertex RAM arbiter: drains loader writes and interleaves fetch reads.
// Reads wait on matching pending writes so they always see the newest data.
module vertex_mem_arbiter
  import vertex_mem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int DW           = 64,
  parameter int WFIFO_DEPTH  = 4,
  parameter int MAX_WR_BURST = 8,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          wr_we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          loader_busy,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          wr_overflow,
  output logic          idle
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam int RW = $clog2(MAX_WR_BURST + 1);

  gnt_state_t             r_state;
  gnt_state_t             w_state_nxt;
  logic [RW-1:0]          r_wr_run;
  logic                   r_ovf;
  logic                   r_idle;
  logic [CW-1:0]          w_count;
  logic                   w_empty;
  logic                   w_drop;
  logic [AW-1:0]          w_head_addr;
  logic [DW-1:0]          w_head_data;
  logic [WFIFO_DEPTH-1:0] w_match;
  logic                   w_new_hz;
  logic                   w_rd_ok;
  logic                   w_do_rd;
  logic                   w_do_wr;

  vertex_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_wfifo (
    .clk         (CLK),
    .rst         (rst),
    .i_push      (wr_we),
    .i_addr      (wr_addr),
    .i_data      (wr_data),
    .i_pop       (w_do_wr),
    .i_q_addr    (rd_addr),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_drop      (w_drop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_match     (w_match)
  );

  // a word being pushed this cycle is not in the match vector yet
  assign w_new_hz = wr_we && (wr_addr == rd_addr);
  assign w_rd_ok  = rd_req && !(|w_match) && !w_new_hz
                 && (w_count < CW'(WFIFO_DEPTH - 1));
  assign w_do_rd  = !rst && w_rd_ok
                 && (w_empty || r_wr_run == RW'(MAX_WR_BURST));
  assign w_do_wr  = !rst && !w_do_rd && !w_empty;

  always_comb begin
    w_state_nxt = ST_IDLE;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    rd_gnt      = 1'b0;
    unique case (1'b1)
      w_do_rd: begin
        w_state_nxt = ST_READ;
        ram_en      = 1'b1;
        ram_addr    = rd_addr;
        rd_gnt      = 1'b1;
      end
      w_do_wr: begin
        w_state_nxt = ST_WRITE;
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = w_head_addr;
        ram_wdata   = w_head_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wr_run <= '0;
      r_ovf    <= 1'b0;
      r_idle   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ST_WRITE) begin
        if (r_wr_run != RW'(MAX_WR_BURST))
          r_wr_run <= r_wr_run + RW'(1);
      end else begin
        r_wr_run <= '0;
      end
      r_ovf  <= r_ovf | w_drop;
      r_idle <= w_empty && (r_state != ST_READ)
             && !loader_busy && !rd_req;
    end
  end

  assign rd_valid    = (r_state == ST_READ);
  assign rd_data     = ram_rdata;
  assign wr_overflow = r_ovf;
  assign idle        = r_idle;

endmodule

// File: tb/tb_vertex_mem_arbiter.sv
// Bench for vertex_mem_arbiter: RAM model, write/read scoreboard,
// directed scenarios plus randomized traffic.
module tb_vertex_mem_arbiter;

  localparam int DEPTH = 1024;
  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int WFD   = 4;
  localparam int MWB   = 8;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          wr_we = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          loader_busy = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          wr_overflow;
  logic          idle;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0]    mem    [DEPTH];
  logic [DW-1:0]    shadow [DEPTH];
  logic [AW+DW-1:0] exp_wr [$];
  logic [AW+DW-1:0] obs_wr [$];
  logic [DW-1:0]    exp_rd [$];
  logic [DW-1:0]    obs_rd [$];
  int pend  = 0;
  int drops = 0;

  vertex_mem_arbiter #(
    .DEPTH(DEPTH), .DW(DW),
    .WFIFO_DEPTH(WFD), .MAX_WR_BURST(MWB)
  ) dut (
    .CLK(CLK), .rst(rst),
    .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .loader_busy(loader_busy),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_overflow(wr_overflow), .idle(idle)
  );

  always #5 CLK = ~CLK;

  // single-port RAM with one cycle read latency
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // reference: accepted writes reach RAM in order; a read returns
  // the newest accepted write to its address before the grant
  always @(posedge CLK) begin
    if (rst) begin
      exp_wr.delete(); obs_wr.delete();
      exp_rd.delete(); obs_rd.delete();
      pend = 0;
    end else begin
      if (rd_gnt)   exp_rd.push_back(shadow[rd_addr]);
      if (rd_valid) obs_rd.push_back(rd_data);
      if (ram_we)   obs_wr.push_back({ram_addr, ram_wdata});
      if (wr_we) begin
        if (pend == WFD && !ram_we) drops++;
        else begin
          exp_wr.push_back({wr_addr, wr_data});
          shadow[wr_addr] = wr_data;
          pend++;
        end
      end
      if (ram_we) pend--;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (pend <= 0 && !rd_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic flush();
    exp_wr.delete(); obs_wr.delete();
    exp_rd.delete(); obs_rd.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_chk++;
    if ({idle, rd_valid, wr_overflow, ram_en, rd_gnt}
        !== 5'b10000)
      $display("FAIL rst_state got=%b exp=10000",
        {idle, rd_valid, wr_overflow, ram_en, rd_gnt});
    else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    logic [DW-1:0] d;
    d = 64'h00C80064_E3000000;
    wr_we = 1'b1; wr_addr = 10'h010; wr_data = d;
    loader_busy = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (ram_en !== 1'b0)
      $display("FAIL wr_lat0 ram_en got=%b exp=0", ram_en);
    else n_pass++;
    tick();
    wr_we = 1'b0; loader_busy = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h010, d})
      $display("FAIL wr_lat1 got=%b/%h/%h exp=1/010/%h",
        ram_we, ram_addr, ram_wdata, d);
    else n_pass++;
    tick();
    @(negedge CLK);
    n_chk++;
    if ({idle, ram_en} !== 2'b00)
      $display("FAIL idle_early got=%b exp=00", {idle, ram_en});
    else n_pass++;
    tick();
    @(negedge CLK);
    n_chk++;
    if (idle !== 1'b1)
      $display("FAIL idle_late got=%b exp=1", idle);
    else n_pass++;
    flush();
  endtask

  task automatic test_read_empty();
    tick();
    rd_req = 1'b1; rd_addr = 10'h010;
    @(negedge CLK);
    n_chk++;
    if ({rd_gnt, ram_en, ram_we, ram_addr}
        !== {3'b110, 10'h010})
      $display("FAIL rd_gnt got=%b%b%b/%h exp=110/010",
        rd_gnt, ram_en, ram_we, ram_addr);
    else n_pass++;
    tick();
    rd_req = 1'b0;
    @(negedge CLK);
    n_chk++;
    if ({rd_valid, rd_data} !== {1'b1, 64'h00C80064_E3000000})
      $display("FAIL rd_data got=%b/%h exp=1/00c80064e3000000",
        rd_valid, rd_data);
    else n_pass++;
    tick();
    @(negedge CLK);
    n_chk++;
    if (rd_valid !== 1'b0)
      $display("FAIL rd_valid_drop got=%b exp=0", rd_valid);
    else n_pass++;
    flush();
  endtask

  task automatic test_stream();
    logic [DW-1:0] d200;
    int  nwr = 0;
    int  bad = 0;
    bit  gnt = 1'b0;
    bit  ok;
    d200 = {$urandom, $urandom};
    tick();
    wr_we = 1'b1; wr_addr = 10'h200; wr_data = d200;
    tick();
    wr_we = 1'b0;
    drain(20, ok);
    flush();
    for (int i = 0; i < 20; i++) begin
      wr_we = 1'b1;
      wr_addr = AW'($urandom_range(0, 511));
      wr_data = {$urandom, $urandom};
      loader_busy = 1'b1;
      if (i == 1) begin
        rd_req = 1'b1; rd_addr = 10'h200;
      end
      @(negedge CLK);
      if (rd_req && rd_gnt) gnt = 1'b1;
      else if (rd_req && ram_we) nwr++;
      tick();
      if (gnt) rd_req = 1'b0;
    end
    wr_we = 1'b0; loader_busy = 1'b0; rd_req = 1'b0;
    drain(50, ok);
    n_chk++;
    if (!gnt || nwr > MWB)
      $display("FAIL burst_bound gnt=%b writes=%0d exp<=%0d",
        gnt, nwr, MWB);
    else n_pass++;
    n_chk++;
    if (!ok || wr_overflow !== 1'b0)
      $display("FAIL stream_drain ok=%b ovf=%b exp=1/0",
        ok, wr_overflow);
    else n_pass++;
    for (int i = 0; i < exp_wr.size(); i++)
      if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) bad++;
    n_chk++;
    if (obs_wr.size() !== 20 || bad != 0)
      $display("FAIL stream_order got=%0d/%0d bad exp=20/0",
        obs_wr.size(), bad);
    else n_pass++;
    n_chk++;
    if (obs_rd.size() !== 1 || obs_rd[0] !== d200)
      $display("FAIL stream_rd got=%0d/%h exp=1/%h",
        obs_rd.size(), obs_rd[0], d200);
    else n_pass++;
    flush();
  endtask

  task automatic test_hazard();
    int wcyc = -1;
    int gcyc = -1;
    wr_we = 1'b1; wr_addr = 10'h055; wr_data = 64'h30;
    loader_busy = 1'b1;
    rd_req = 1'b1; rd_addr = 10'h055;
    for (int c = 0; c < 10 && gcyc < 0; c++) begin
      @(negedge CLK);
      if (ram_we && ram_addr == 10'h055) wcyc = c;
      if (rd_gnt) gcyc = c;
      tick();
      wr_we = 1'b0; loader_busy = 1'b0;
      if (gcyc >= 0) rd_req = 1'b0;
    end
    rd_req = 1'b0;
    n_chk++;
    if (wcyc < 0 || gcyc <= wcyc)
      $display("FAIL hz_order wr_cyc=%0d gnt_cyc=%0d exp gnt>wr",
        wcyc, gcyc);
    else n_pass++;
    @(negedge CLK);
    n_chk++;
    if ({rd_valid, rd_data} !== {1'b1, 64'h30})
      $display("FAIL hz_data got=%b/%h exp=1/30",
        rd_valid, rd_data);
    else n_pass++;
    tick();
    flush();
  endtask

  task automatic test_random();
    int  wc = 0;
    int  late = 0;
    int  bad = 0;
    bit  g;
    bit  ok;
    for (int i = 0; i < 16; i++) begin
      wr_we = 1'b1; wr_addr = AW'(i);
      wr_data = {$urandom, $urandom};
      tick();
    end
    wr_we = 1'b0;
    drain(30, ok);
    flush();
    for (int c = 0; c < 300; c++) begin
      wr_we   = ($urandom_range(0, 1) == 1);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = {$urandom, $urandom};
      loader_busy = 1'b1;
      if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_req = 1'b1;
        rd_addr = AW'($urandom_range(0, 15));
        wc = 0;
      end
      @(negedge CLK);
      g = rd_req && rd_gnt;
      if (rd_req && !g) begin
        wc++;
        if (wc == 64) late++;
      end
      tick();
      if (g) rd_req = 1'b0;
    end
    wr_we = 1'b0; loader_busy = 1'b0;
    for (int c = 0; c < 20 && rd_req; c++) begin
      @(negedge CLK);
      g = rd_gnt;
      tick();
      if (g) rd_req = 1'b0;
    end
    if (rd_req) late++;
    rd_req = 1'b0;
    drain(50, ok);
    n_chk++;
    if (!ok || late != 0)
      $display("FAIL rnd_progress ok=%b starved=%0d exp=1/0",
        ok, late);
    else n_pass++;
    for (int i = 0; i < exp_wr.size(); i++)
      if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) bad++;
    n_chk++;
    if (obs_wr.size() !== exp_wr.size() || bad != 0)
      $display("FAIL rnd_writes got=%0d exp=%0d bad=%0d",
        obs_wr.size(), exp_wr.size(), bad);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < exp_rd.size(); i++)
      if (i >= obs_rd.size() || obs_rd[i] !== exp_rd[i]) bad++;
    n_chk++;
    if (obs_rd.size() !== exp_rd.size() || bad != 0)
      $display("FAIL rnd_reads got=%0d exp=%0d bad=%0d",
        obs_rd.size(), exp_rd.size(), bad);
    else n_pass++;
    n_chk++;
    if (wr_overflow !== 1'b0)
      $display("FAIL rnd_ovf got=%b exp=0", wr_overflow);
    else n_pass++;
    flush();
  endtask

  task automatic test_overflow();
    int bad = 0;
    bit ok;
    rd_req = 1'b1; rd_addr = 10'h3FF;
    force dut.w_do_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_we = 1'b1; wr_addr = AW'(10'h300 + i);
      wr_data = {$urandom, $urandom};
      loader_busy = 1'b1;
      tick();
    end
    wr_we = 1'b0; loader_busy = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (wr_overflow !== 1'b1)
      $display("FAIL ovf_set got=%b exp=1", wr_overflow);
    else n_pass++;
    release dut.w_do_rd;
    rd_req = 1'b0;
    drain(30, ok);
    repeat (3) tick();
    @(negedge CLK);
    n_chk++;
    if (!ok || wr_overflow !== 1'b1)
      $display("FAIL ovf_sticky ok=%b got=%b exp=1/1",
        ok, wr_overflow);
    else n_pass++;
    for (int i = 0; i < exp_wr.size(); i++)
      if (i >= obs_wr.size() || obs_wr[i] !== exp_wr[i]) bad++;
    n_chk++;
    if (obs_wr.size() !== 4 || bad != 0)
      $display("FAIL ovf_kept got=%0d bad=%0d exp=4/0",
        obs_wr.size(), bad);
    else n_pass++;
    tick();
    flush();
  endtask

  task automatic test_reset_midflight();
    int en_seen = 0;
    int v_seen  = 0;
    int nidle   = 0;
    rd_req = 1'b1; rd_addr = 10'h3C0;
    force dut.w_do_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_we = 1'b1; wr_addr = AW'(10'h3C1 + i);
      wr_data = {$urandom, $urandom};
      loader_busy = 1'b1;
      tick();
    end
    wr_we = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (rd_valid !== 1'b1)
      $display("FAIL mid_inflight got=%b exp=1", rd_valid);
    else n_pass++;
    rst = 1'b1;
    release dut.w_do_rd;
    rd_req = 1'b0; loader_busy = 1'b0;
    #1;
    n_chk++;
    if ({ram_en, rd_valid, rd_gnt} !== 3'b000)
      $display("FAIL mid_rst_now got=%b exp=000",
        {ram_en, rd_valid, rd_gnt});
    else n_pass++;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (ram_en) en_seen++;
      if (rd_valid) v_seen++;
      if (idle) nidle++;
      tick();
    end
    n_chk++;
    if (en_seen != 0 || v_seen != 0)
      $display("FAIL mid_quiet ram_en=%0d rd_valid=%0d exp=0/0",
        en_seen, v_seen);
    else n_pass++;
    n_chk++;
    if (nidle != 6 || wr_overflow !== 1'b0)
      $display("FAIL mid_idle idle=%0d ovf=%b exp=6/0",
        nidle, wr_overflow);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_empty();
    test_stream();
    test_hazard();
    test_random();
    test_overflow();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
